program_loader: RTL and testbench

- Serial bootstrap writer for ARMAria instruction memory.
- Receives a framed program over a UART line (8N1) and writes 16-bit instruction words into memory through a ready/valid write port.
- Holds the processor in reset while a load is in progress.
- Runs on fast_clock, beside MemoryUnit; it is the producer side of the instruction-fetch path.

---
 rtl/program_loader.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_program_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader
//   Serial bootstrap writer for the ARMAria instruction memory. Receives a
//   framed program over an 8N1 UART line and writes 16-bit instruction words
//   through a ready/valid write port while holding the CPU in reset.
//
//   Frame: A5, LEN_HI, LEN_LO, 2*N payload bytes (big-endian words), CHK
//   CHK  : 8-bit sum of LEN_HI, LEN_LO and all payload bytes.
//
// Ports
//   fast_clock  in   system clock
//   reset       in   asynchronous active-low reset
//   rx          in   UART line, idle high (synchronised internally)
//   mem_ready   in   memory accepts the write this cycle
//   mem_write   out  write request (valid)
//   mem_address out  word address   [WORD_SIZE]
//   mem_data    out  instruction    [INSTRUCTION_WIDTH]
//   hold_cpu    out  high from sync byte until DONE/ERROR
//   busy        out  loader FSM is mid-frame
//   done        out  sticky, good frame
//   error       out  sticky, failed frame
//   error_code  out  1 length, 2 framing, 3 checksum, 4 overrun, 5 timeout
//
// Build option
//   LOADER_TIMEOUT_EN : enables the inter-byte timeout (error_code 5).
module program_loader #(
  parameter int unsigned           CLOCK_HZ          = 50000000,
  parameter int unsigned           BAUD              = 115200,
  parameter int unsigned           WORD_SIZE         = 32,
  parameter int unsigned           INSTRUCTION_WIDTH = 16,
  parameter logic [WORD_SIZE-1:0]  BASE_ADDRESS      = '0,
  parameter int unsigned           MAX_WORDS         = 4096,
  parameter int unsigned           TIMEOUT_CYCLES    = 5000000
) (
  input  logic                         fast_clock,
  input  logic                         reset,
  input  logic                         rx,
  input  logic                         mem_ready,
  output logic                         mem_write,
  output logic [WORD_SIZE-1:0]         mem_address,
  output logic [INSTRUCTION_WIDTH-1:0] mem_data,
  output logic                         hold_cpu,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [2:0]                   error_code
);

  localparam int unsigned CPB   = CLOCK_HZ / BAUD;
  localparam int unsigned HALF  = CPB / 2;
  localparam int unsigned CNT_W = $clog2(CPB + 1);
  localparam logic [CNT_W-1:0] CPB_LAST  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  if (CPB < 4 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("program_loader: CLOCK_HZ/BAUD must be >= 4 and TIMEOUT_CYCLES > 0");
  end

  // ---------------------------------------------------------------------
  // rx synchroniser; flops reset high so reset release never looks like a
  // start bit.
  // ---------------------------------------------------------------------
  logic rx_s1_q, rx_s2_q, rx_prev_q;

  always_ff @(posedge fast_clock or negedge reset) begin
    if (!reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // ---------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_done, frame_err;

  always_comb begin
    rx_state_d = rx_state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_done  = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        // Re-check the line half a bit later; a high level was a glitch.
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d  = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == CPB_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == CPB_LAST) begin
          rx_state_d = RX_IDLE;
          if (rx_s2_q) byte_done = 1'b1;
          else         frame_err = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge fast_clock or negedge reset) begin
    if (!reset) begin
      rx_state_q <= RX_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
    end
  end

  // ---------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------
  typedef enum logic [3:0] {
    ST_IDLE, ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO,
    ST_WRITE, ST_CHECK, ST_DONE, ST_ERROR
  } state_e;

  state_e                       state_q, state_d;
  logic                         hold_q, hold_d;
  logic                         done_q, done_d;
  logic                         error_q, error_d;
  logic [2:0]                   code_q, code_d;
  logic [WORD_SIZE-1:0]         addr_q, addr_d;
  logic [INSTRUCTION_WIDTH-1:0] data_q, data_d;
  logic [7:0]                   hi_q, hi_d;
  logic [15:0]                  remaining_q, remaining_d;
  logic [7:0]                   sum_q, sum_d;
  logic [7:0]                   rx_byte_q;
  logic                         rx_full_q;

  logic        is_busy, consume, overrun, timeout_hit, fail;
  logic [2:0]  fail_code;
  logic [15:0] len;

  assign is_busy = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});

  // Every state except WRITE drains a full buffer in the cycle it sees it,
  // so only WRITE can leave a byte waiting long enough to be overrun. A byte
  // landing in the consume cycle therefore never counts as an overrun.
  assign consume = rx_full_q && (state_q != ST_WRITE);
  assign overrun = byte_done && rx_full_q && (state_q == ST_WRITE);
  assign len     = {hi_q, rx_byte_q};

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    done_d      = done_q;
    error_d     = error_q;
    code_d      = code_q;
    addr_d      = addr_q;
    data_d      = data_q;
    hi_d        = hi_q;
    remaining_d = remaining_q;
    sum_d       = sum_q;
    fail        = 1'b0;
    fail_code   = 3'd0;

    if (!is_busy) begin
      // IDLE, DONE and ERROR all wait for a sync byte; line framing errors
      // here are noise between frames and are ignored.
      if (rx_full_q && rx_byte_q == 8'hA5) begin
        done_d  = 1'b0;
        error_d = 1'b0;
        code_d  = 3'd0;
        hold_d  = 1'b1;
        sum_d   = 8'h00;
        state_d = ST_LEN_HI;
      end
    end else if (frame_err) begin
      fail      = 1'b1;
      fail_code = 3'd2;
    end else if (overrun) begin
      fail      = 1'b1;
      fail_code = 3'd4;
    end else if (timeout_hit) begin
      fail      = 1'b1;
      fail_code = 3'd5;
    end else begin
      case (state_q)
        ST_LEN_HI: if (rx_full_q) begin
          hi_d    = rx_byte_q;
          sum_d   = sum_q + rx_byte_q;
          state_d = ST_LEN_LO;
        end
        ST_LEN_LO: if (rx_full_q) begin
          sum_d = sum_q + rx_byte_q;
          if (len == 16'd0 || 32'(len) > MAX_WORDS) begin
            fail      = 1'b1;
            fail_code = 3'd1;
          end else begin
            addr_d      = BASE_ADDRESS;
            remaining_d = len;
            state_d     = ST_DATA_HI;
          end
        end
        ST_DATA_HI: if (rx_full_q) begin
          hi_d    = rx_byte_q;
          sum_d   = sum_q + rx_byte_q;
          state_d = ST_DATA_LO;
        end
        ST_DATA_LO: if (rx_full_q) begin
          data_d  = INSTRUCTION_WIDTH'({hi_q, rx_byte_q});
          sum_d   = sum_q + rx_byte_q;
          state_d = ST_WRITE;
        end
        ST_WRITE: if (mem_ready) begin
          addr_d      = addr_q + WORD_SIZE'(1);
          remaining_d = remaining_q - 16'd1;
          state_d     = (remaining_q == 16'd1) ? ST_CHECK : ST_DATA_HI;
        end
        ST_CHECK: if (rx_full_q) begin
          if (rx_byte_q == sum_q) begin
            done_d  = 1'b1;
            hold_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            fail      = 1'b1;
            fail_code = 3'd3;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (fail) begin
      state_d = ST_ERROR;
      error_d = 1'b1;
      code_d  = fail_code;
      hold_d  = 1'b0;
    end
  end

  always_ff @(posedge fast_clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      hold_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      code_q      <= 3'd0;
      addr_q      <= '0;
      data_q      <= '0;
      hi_q        <= '0;
      remaining_q <= '0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
      code_q      <= code_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      hi_q        <= hi_d;
      remaining_q <= remaining_d;
      sum_q       <= sum_d;
    end
  end

  // One-entry receive buffer.
  always_ff @(posedge fast_clock or negedge reset) begin
    if (!reset) begin
      rx_byte_q <= '0;
      rx_full_q <= 1'b0;
    end else if (byte_done) begin
      rx_byte_q <= shift_q;
      rx_full_q <= 1'b1;
    end else if (consume) begin
      rx_full_q <= 1'b0;
    end
  end

`ifdef LOADER_TIMEOUT_EN
  // Cycles since the last received byte; frozen while a write is stalled so
  // a slow memory cannot trip the timeout.
  logic [31:0] to_cnt_q;

  always_ff @(posedge fast_clock or negedge reset) begin
    if (!reset)                       to_cnt_q <= '0;
    else if (!is_busy || byte_done)   to_cnt_q <= '0;
    else if (state_q != ST_WRITE)     to_cnt_q <= to_cnt_q + 32'd1;
  end

  assign timeout_hit = (state_q != ST_WRITE) && (to_cnt_q >= 32'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  assign mem_write   = (state_q == ST_WRITE);
  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign hold_cpu    = hold_q;
  assign busy        = is_busy;
  assign done        = done_q;
  assign error       = error_q;
  assign error_code  = code_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader at 16 clocks per UART bit,
// BASE_ADDRESS = 0x100.
module tb_program_loader;

  logic        fast_clock = 1'b0;
  logic        reset;
  logic        rx;
  logic        mem_ready;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [15:0] mem_data;
  logic        hold_cpu, busy, done, error;
  logic [2:0]  error_code;

  int checks   = 0;
  int failures = 0;

  program_loader #(
    .CLOCK_HZ(16), .BAUD(1), .WORD_SIZE(32), .INSTRUCTION_WIDTH(16),
    .BASE_ADDRESS(32'h100), .MAX_WORDS(4096), .TIMEOUT_CYCLES(1000)
  ) dut (
    .fast_clock(fast_clock), .reset(reset), .rx(rx), .mem_ready(mem_ready),
    .mem_write(mem_write), .mem_address(mem_address), .mem_data(mem_data),
    .hold_cpu(hold_cpu), .busy(busy), .done(done), .error(error),
    .error_code(error_code)
  );

  always #5 fast_clock = ~fast_clock;

  // Accepted writes and cycles with mem_write high, as seen by the memory.
  logic [31:0] wr_addr[$];
  logic [15:0] wr_data[$];
  int          wc_total = 0;

  always @(posedge fast_clock) begin
    if (mem_write) wc_total++;
    if (mem_write && mem_ready) begin
      wr_addr.push_back(mem_address);
      wr_data.push_back(mem_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge fast_clock);
  endtask

  task automatic drive_bit(input logic v);
    #1 rx = v;
    repeat (16) @(posedge fast_clock);
  endtask

  // One 8N1 character; stop selects the stop-bit level.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge fast_clock);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    #1 rx = 1'b1;
    repeat (4) @(posedge fast_clock);
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, {24'd0, mem_write, hold_cpu, busy, done, error, error_code}, 32'd0);
    check({tag, "_addr"}, mem_address, 32'd0);
    check({tag, "_data"}, {16'd0, mem_data}, 32'd0);
  endtask

  int  n0, w0;
  logic stable;

  initial begin
    reset     = 1'b0;
    rx        = 1'b1;
    mem_ready = 1'b1;
    settle(5);
    check_all_zero("reset");
    reset = 1'b1;
    settle(5);

    // Good two-word frame. CHK = 00+02+12+34+AB+CD = 0x1C0 -> 0xC0.
    n0 = wr_addr.size();
    send(8'hA5);
    settle(2);
    check("t1_hold_after_sync", {31'd0, hold_cpu}, 32'd1);
    check("t1_busy_after_sync", {31'd0, busy}, 32'd1);
    send(8'h00); send(8'h02); send(8'h12); send(8'h34);
    send(8'hAB); send(8'hCD); send(8'hC0);
    settle(4);
    check("t1_nwrites", wr_addr.size() - n0, 32'd2);
    check("t1_addr0", wr_addr[n0], 32'h100);
    check("t1_data0", {16'd0, wr_data[n0]}, 32'h1234);
    check("t1_addr1", wr_addr[n0+1], 32'h101);
    check("t1_data1", {16'd0, wr_data[n0+1]}, 32'hABCD);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_error", {31'd0, error}, 32'd0);
    check("t1_hold_released", {31'd0, hold_cpu}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd0);

    // First write stalled long enough that the next byte lands in the
    // buffer behind it; this must not be treated as an overrun.
    n0 = wr_addr.size();
    mem_ready = 1'b0;
    send(8'hA5); send(8'h00); send(8'h02); send(8'h12); send(8'h34);
    settle(1);
    check("t2_write_req", {31'd0, mem_write}, 32'd1);
    check("t2_addr", mem_address, 32'h100);
    check("t2_data", {16'd0, mem_data}, 32'h1234);
    fork
      begin
        send(8'hAB); send(8'hCD); send(8'hC0);
      end
      begin
        stable = 1'b1;
        repeat (200) begin
          @(negedge fast_clock);
          if (mem_write !== 1'b1 || mem_address !== 32'h100 || mem_data !== 16'h1234)
            stable = 1'b0;
        end
        mem_ready = 1'b1;
      end
    join
    settle(4);
    check("t2_stall_stable", {31'd0, stable}, 32'd1);
    check("t2_nwrites", wr_addr.size() - n0, 32'd2);
    check("t2_addr1", wr_addr[n0+1], 32'h101);
    check("t2_data1", {16'd0, wr_data[n0+1]}, 32'hABCD);
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_error", {31'd0, error}, 32'd0);

    // Bad checksum: words still written, then error code 3.
    n0 = wr_addr.size();
    send(8'hA5);
    settle(2);
    check("t3_done_cleared", {31'd0, done}, 32'd0);
    send(8'h00); send(8'h02); send(8'h12); send(8'h34);
    send(8'hAB); send(8'hCD); send(8'hC1);
    settle(4);
    check("t3_nwrites", wr_addr.size() - n0, 32'd2);
    check("t3_error", {31'd0, error}, 32'd1);
    check("t3_code", {29'd0, error_code}, 32'd3);
    check("t3_done", {31'd0, done}, 32'd0);
    check("t3_hold", {31'd0, hold_cpu}, 32'd0);

    // Zero length.
    w0 = wc_total;
    send(8'hA5);
    settle(2);
    check("t4_error_cleared", {31'd0, error}, 32'd0);
    check("t4_code_cleared", {29'd0, error_code}, 32'd0);
    send(8'h00); send(8'h00);
    settle(4);
    check("t4_len0_code", {29'd0, error_code}, 32'd1);
    check("t4_len0_error", {31'd0, error}, 32'd1);
    check("t4_len0_nowrite", wc_total - w0, 32'd0);
    check("t4_len0_hold", {31'd0, hold_cpu}, 32'd0);

    // N = 4097, one past the limit.
    send(8'hA5); send(8'h10); send(8'h01);
    settle(4);
    check("t4_len4097_code", {29'd0, error_code}, 32'd1);
    check("t4_len4097_nowrite", wc_total - w0, 32'd0);

    // Framing error on LEN_LO.
    send(8'hA5); send(8'h00); send_byte(8'h02, 1'b0);
    settle(4);
    check("t5_frame_code", {29'd0, error_code}, 32'd2);
    check("t5_frame_error", {31'd0, error}, 32'd1);
    check("t5_frame_hold", {31'd0, hold_cpu}, 32'd0);

    // N = 4096 is accepted; then reset lands in the middle of a payload byte.
    send(8'hA5); send(8'h10); send(8'h00);
    settle(2);
    check("t6_len4096_busy", {31'd0, busy}, 32'd1);
    check("t6_len4096_noerr", {31'd0, error}, 32'd0);
    send(8'h12);
    fork
      send(8'h34);
      begin
        repeat (60) @(posedge fast_clock);
        #2 reset = 1'b0;
        #1 check_all_zero("t6_reset_mid");
      end
    join
    @(negedge fast_clock) reset = 1'b1;
    settle(4);

    // IDLE: a short low glitch and a bad-stop character are both ignored.
    @(posedge fast_clock);
    #1 rx = 1'b0;
    repeat (4) @(posedge fast_clock);
    #1 rx = 1'b1;
    settle(200);
    check("t7_glitch_busy", {31'd0, busy}, 32'd0);
    check("t7_glitch_error", {31'd0, error}, 32'd0);
    send_byte(8'hA5, 1'b0);
    settle(4);
    check("t7_idle_frame_error", {31'd0, error}, 32'd0);
    check("t7_idle_frame_hold", {31'd0, hold_cpu}, 32'd0);

    // Overrun: two bytes arrive while a write is stalled.
    mem_ready = 1'b0;
    send(8'hA5);
    settle(2);
    check("t7_resync_hold", {31'd0, hold_cpu}, 32'd1);
    send(8'h00); send(8'h01); send(8'h12); send(8'h34);
    send(8'hAB); send(8'hCD);
    settle(4);
    check("t7_overrun_code", {29'd0, error_code}, 32'd4);
    check("t7_overrun_memwrite", {31'd0, mem_write}, 32'd0);
    check("t7_overrun_hold", {31'd0, hold_cpu}, 32'd0);
    mem_ready = 1'b1;

`ifdef LOADER_TIMEOUT_EN
    send(8'hA5); send(8'h00);
    settle(900);
    check("t8_before_timeout", {31'd0, error}, 32'd0);
    settle(150);
    check("t8_timeout_code", {29'd0, error_code}, 32'd5);
    check("t8_timeout_hold", {31'd0, hold_cpu}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
